// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, ExcCodes and
// packed views of the Status/Cause fields that actually hold state.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam int ST_IE      = 0;
  localparam int ST_EXL     = 1;
  localparam int ST_IM_LSB  = 8;
  localparam int CA_EXC_LSB = 2;
  localparam int CA_IP_LSB  = 8;
  localparam int CA_BD      = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  // Hardware IP bits are sampled separately; only the software IP bits live here.
  typedef struct packed {
    logic       bd;
    logic [1:0] ip_sw;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic [31:0] status_word(status_t s);
    return {16'b0, s.im, 6'b0, s.exl, s.ie};
  endfunction

  function automatic logic [31:0] cause_word(cause_t c, logic [7:0] ip);
    return {c.bd, 15'b0, ip, 1'b0, c.exc_code, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Core <-> CP0 bus: MFC0/MTC0 access, exception/ERET requests, redirect outputs.
interface cp0_exc_unit_if;
  // Every request is a single-cycle strobe (rd_en, wr_en, exc_req, eret) with
  // its payload valid only while the strobe is high; there is no back-pressure.
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic        exc_take;
  logic [31:0] exc_target;
  logic        int_pending;

  modport master (
    output rd_en, rd_addr, rd_sel, wr_en, wr_addr, wr_sel, wr_data,
    output exc_req, exc_code, exc_pc, exc_bd, eret,
    input  rd_data, exc_take, exc_target, int_pending
  );

  modport slave (
    input  rd_en, rd_addr, rd_sel, wr_en, wr_addr, wr_sel, wr_data,
    input  exc_req, exc_code, exc_pc, exc_bd, eret,
    output rd_data, exc_take, exc_target, int_pending
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, sticky TI on Count==Compare,
// cleared by any Compare write.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = wr_count ? wr_data : count_q + 32'd1;
    compare_d = wr_compare ? wr_data : compare_q;
    ti_d      = ti_q;
    if (wr_compare)
      ti_d = 1'b0;
    else if (count_q == compare_q)
      ti_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor 0 for the multi-cycle MIPS core: Status/Cause/EPC, interrupt
// arbitration, exception entry and ERET. Define CP0_TIMER_EN to add Count/Compare.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] hw_int,
  cp0_exc_unit_if.slave         bus
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("cp0_exc_unit: only DATA_W=32 is supported");
  end
  if (NUM_HW_INT < 1 || NUM_HW_INT > 6) begin : g_bad_num_hw_int
    $error("cp0_exc_unit: NUM_HW_INT must be 1..6");
  end

  status_t     status_q, status_d;
  cause_t      cause_q, cause_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [31:0] epc_q, epc_d;
  logic        take_q, take_d;
  logic [31:0] target_q, target_d;

  logic        ti;
  logic [31:0] count_rd, compare_rd;
  logic        wr_ok, rd_ok, enter, pending;
  logic [7:0]  ip_full;

  assign wr_ok = bus.wr_en && (bus.wr_sel == 3'd0);
  assign rd_ok = bus.rd_en && (bus.rd_sel == 3'd0);

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_count   (wr_ok && (bus.wr_addr == REG_COUNT)),
    .wr_compare (wr_ok && (bus.wr_addr == REG_COMPARE)),
    .wr_data    (bus.wr_data),
    .count      (count_rd),
    .compare    (compare_rd),
    .ti         (ti)
  );
`else
  assign count_rd   = '0;
  assign compare_rd = '0;
  assign ti         = 1'b0;
`endif

  // The timer interrupt shares IP[7] with the last hardware line.
  assign ip_full = {ip_hw_q[5] | ti, ip_hw_q[4:0], cause_q.ip_sw};
  assign pending = status_q.ie & ~status_q.exl & (|(ip_full & status_q.im));
  assign enter   = bus.exc_req | pending;

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    take_d   = 1'b0;
    target_d = '0;
    ip_hw_d  = '0;
    ip_hw_d[NUM_HW_INT-1:0] = hw_int;

    if (wr_ok) begin
      case (bus.wr_addr)
        REG_STATUS: status_d = '{im: bus.wr_data[15:8], exl: bus.wr_data[ST_EXL], ie: bus.wr_data[ST_IE]};
        REG_CAUSE:  cause_d.ip_sw = bus.wr_data[9:8];
        REG_EPC:    epc_d = bus.wr_data;
        default:    ;
      endcase
    end

    // Entry/ERET fields override a same-cycle MTC0; an eret loses to entry.
    if (enter) begin
      if (!status_q.exl) begin
        epc_d      = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
        cause_d.bd = bus.exc_bd;
      end
      cause_d.exc_code = bus.exc_req ? bus.exc_code : EXC_INT;
      status_d.exl     = 1'b1;
      take_d           = 1'b1;
      target_d         = EXC_VECTOR;
    end else if (bus.eret) begin
      status_d.exl = 1'b0;
      take_d       = 1'b1;
      target_d     = epc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      cause_q  <= '0;
      ip_hw_q  <= '0;
      epc_q    <= '0;
      take_q   <= 1'b0;
      target_q <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      ip_hw_q  <= ip_hw_d;
      epc_q    <= epc_d;
      take_q   <= take_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    if (rd_ok) begin
      case (bus.rd_addr)
        REG_STATUS:  bus.rd_data = status_word(status_q);
        REG_CAUSE:   bus.rd_data = cause_word(cause_q, ip_full);
        REG_EPC:     bus.rd_data = epc_q;
        REG_COUNT:   bus.rd_data = count_rd;
        REG_COMPARE: bus.rd_data = compare_rd;
        default:     bus.rd_data = '0;
      endcase
    end
  end

  assign bus.exc_take    = take_q;
  assign bus.exc_target  = target_q;
  assign bus.int_pending = pending;

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Parametrised coprocessor-0 for the multi-cycle MIPS core.
- Holds Status, Cause and EPC, plus optional Count and Compare.
- Samples hardware interrupt lines, arbitrates exceptions against interrupts, performs exception entry (EPC/Cause/EXL update) and ERET return.
- Supplies the control unit with a one-cycle redirect pulse and target PC.

Parameters:
- DATA_W, 32, register/data width; only 32 supported, checked at elaboration.
- NUM_HW_INT, 6, hardware interrupt lines, 1..6; mapped to Cause.IP[2 +: NUM_HW_INT].
- EXC_VECTOR, 32'h0000_0004, handler entry PC driven on exc_target.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- rd_en  in  1  MFC0 read strobe.
- rd_addr  in  5  CP0 register number for read.
- rd_sel  in  3  select field for read.
- rd_data  out  32  read data, combinational.
- wr_en  in  1  MTC0 write strobe.
- wr_addr  in  5  CP0 register number for write.
- wr_sel  in  3  select field for write.
- wr_data  in  32  write data.
- exc_req  in  1  synchronous exception raised by datapath this cycle.
- exc_code  in  5  ExcCode for exc_req.
- exc_pc  in  32  PC of faulting instruction.
- exc_bd  in  1  faulting instruction sits in a branch delay slot.
- eret  in  1  ERET executing this cycle.
- hw_int  in  NUM_HW_INT  level-sensitive interrupt lines.
- exc_take  out  1  registered one-cycle pulse: redirect PC to exc_target.
- exc_target  out  32  EXC_VECTOR on exception, EPC on ERET.
- int_pending  out  1  enabled interrupt awaiting service.

Behaviour:
- Reset: on rising clk with rst=1, every register and every output is cleared to 0; exc_take=0. Reset mid-entry cancels the pulse.
- Register map (sel must be 0; otherwise read 0, write ignored):
  - Status = 12: IE bit0, EXL bit1, IM[15:8]; other bits read 0.
  - Cause = 13: BD bit31, IP[15:8], ExcCode[6:2]. Only IP[9:8] (software interrupts) are MTC0-writable.
  - EPC = 14: fully writable.
- Unmapped rd_addr reads 0. rd_en=0 forces rd_data=0.
- Read-during-write to the same register returns the old value.
- Interrupt sampling: Cause.IP[2+i] <= hw_int[i] every cycle (one-cycle register delay).
- Interrupt condition: int_pending = IE & ~EXL & |(Cause.IP & Status.IM), combinational from registered state.
- Arbitration each cycle, highest priority first:
  1. rst
  2. exc_req
  3. int_pending (taken as ExcCode 0, using exc_pc as the restart PC)
  4. eret
  5. MTC0 write
- Exception/interrupt entry, one edge:
  - If EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and BD <= exc_bd.
  - If EXL=1: EPC and BD are unchanged.
  - ExcCode <= code; EXL <= 1.
  - Next cycle: exc_take=1, exc_target=EXC_VECTOR.
- ERET: EXL <= 0. Next cycle: exc_take=1, exc_target=EPC.
- An eret coinciding with exc_req or a taken interrupt is discarded.
- Same-cycle write and entry/ERET: fields touched by entry/ERET take the new entry value; other written fields are still written.
- exc_take never asserts on consecutive cycles from a single request. The datapath holds no request for more than one cycle.
- Arithmetic: EPC-4 wraps modulo 2^32.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined:
  - Count (9) increments by 1 every cycle, wraps at 2^32, and is writable.
  - Compare (11) is writable; writing Compare clears the timer interrupt (TI).
  - Count == Compare sets TI, which is held until a Compare write.
  - TI is ORed into Cause.IP[7].
  - A Count write takes precedence over the increment.
- Not defined: registers 9/11 read 0, writes ignored, IP[7] driven only by hw_int[5] if present.

Decomposition:
- Package cp0_pkg:
  - register numbers: CAUSE=13, EPC=14, STATUS=12, COUNT=9, COMPARE=11
  - Status/Cause bit-position constants
  - ExcCode constants: INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12
- One sub-module, cp0_timer: Count/Compare/TI, instantiated only under CP0_TIMER_EN.

Test Plan:
1. Reset then MFC0 of 12/13/14 -> all read 32'h0. Read with sel=1 -> 0.
2. MTC0 Status=32'h0000_FF01; MTC0 Cause=32'hFFFF_FFFF -> Status reads 0000_FF01, Cause reads 0000_0300.
3. exc_req, code=8, exc_pc=32'h0000_1000, bd=0 -> next cycle exc_take=1, exc_target=0000_0004; EPC=0000_1000; Cause=0000_0020; EXL=1.
4. exc_bd=1, exc_pc=32'h0000_2004 -> EPC=0000_2000, Cause.BD=1. A second exc_req while EXL=1 -> EPC unchanged, ExcCode updated.
5. IE=1, IM[10]=1, hw_int[0] rises -> int_pending after 1 cycle; entry with ExcCode 0. ERET -> exc_take=1, exc_target=EPC, EXL=0.
6. With CP0_TIMER_EN: Count=0, Compare=5, IM[15]=1, IE=1 -> IP[7] set at cycle 5, interrupt taken; Compare write clears IP[7].
